// File: rtl/rect_fill_engine_v2_pkg.sv
// Shared types and constants for the fill-rectangle engine: command fields, FSM states, byte-enable masks.
package rect_fill_engine_v2_pkg;

    localparam int unsigned CMD_W   = 88;
    localparam int unsigned FIELD_W = 16;
    localparam int unsigned PIX_W   = 16;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned WBEN_W  = 4;

    localparam logic [WBEN_W-1:0] WBEN_LO  = 4'b0011;
    localparam logic [WBEN_W-1:0] WBEN_HI  = 4'b1100;
    localparam logic [WBEN_W-1:0] WBEN_ALL = 4'b1111;
    localparam logic              OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ROW   = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } fill_state_t;

    typedef struct packed {
        logic [FIELD_W-1:0] x;
        logic [FIELD_W-1:0] y;
        logic [FIELD_W-1:0] w;
        logic [FIELD_W-1:0] h;
        logic [3:0]         r;
        logic [3:0]         g;
        logic [3:0]         b;
    } fill_cmd_t;

    // Wire format stores each 16-bit field with its bytes swapped.
    function automatic logic [FIELD_W-1:0] swap16(input logic [FIELD_W-1:0] v);
        return {v[7:0], v[15:8]};
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is legal when a pop happens in the same cycle.
module fifo #(
    parameter int unsigned DATA_WIDTH = 88,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned LOG2       = 5
) (
    input  logic                  clk,
    input  logic                  rst_,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full_c,
    output logic                  empty_c
);
    localparam int unsigned CNT_W = LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [LOG2-1:0]       wr_ptr_q;
    logic [LOG2-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    assign full_c  = (count_q == CNT_W'(DEPTH));
    assign empty_c = (count_q == '0);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + LOG2'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + LOG2'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: rtl/rect_word_gen.sv
// Per-row word walker: word address, remaining-word count and edge byte enables for the current word.
module rect_word_gen
    import rect_fill_engine_v2_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst_,
    input  logic                load,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [FIELD_W-1:0]  nwords,
    input  logic                first_hi,
    input  logic                last_lo,
    input  logic                advance,
    output logic [ADDR_W-1:0]   addr,
    output logic [WBEN_W-1:0]   wben,
    output logic                last_c
);
    logic [ADDR_W-1:0]  addr_q;
    logic [WBEN_W-1:0]  wben_q;
    logic [FIELD_W-1:0] remain_q;
    logic               last_lo_q;
    logic [WBEN_W-1:0]  first_mask_c;
    logic [WBEN_W-1:0]  last_mask_c;

    assign first_mask_c = first_hi ? WBEN_HI : WBEN_ALL;
    assign last_mask_c  = last_lo  ? WBEN_LO : WBEN_ALL;
    assign addr   = addr_q;
    assign wben   = wben_q;
    assign last_c = (remain_q == FIELD_W'(1));

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            addr_q    <= '0;
            wben_q    <= '0;
            remain_q  <= '0;
            last_lo_q <= 1'b0;
        end else if (load) begin
            addr_q    <= base_addr;
            remain_q  <= nwords;
            last_lo_q <= last_lo;
            wben_q    <= (nwords == FIELD_W'(1)) ? (first_mask_c & last_mask_c) : first_mask_c;
        end else if (advance) begin
            addr_q   <= addr_q + ADDR_W'(1);
            remain_q <= remain_q - FIELD_W'(1);
            // The word about to become current is the last one when two remain now.
            wben_q   <= (remain_q == FIELD_W'(2) && last_lo_q) ? WBEN_LO : WBEN_ALL;
        end
    end
endmodule

// File: rtl/rect_fill_engine_v2.sv
// Fill-rectangle engine: buffers FILL_RECT commands and emits byte-masked 32-bit framebuffer writes.
// Optional clipping to the framebuffer is enabled by defining RECT_CLIP_EN.
module rect_fill_engine_v2
    import rect_fill_engine_v2_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 320,
    parameter int unsigned FB_HEIGHT = 240,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned CMD_DEPTH = 32,
    parameter int unsigned CMD_LOG2  = 5
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic [87:0]       cmd_in_data,
    input  logic              cmd_in_rts,
    output logic              cmd_in_rtr,
    output logic [31:0]       arb_out_data,
    output logic [ADDR_W-1:0] arb_out_addr,
    output logic [3:0]        arb_out_wben,
    output logic              arb_out_op,
    output logic              arb_out_rts,
    input  logic              arb_in_rtr,
    output logic              busy,
    output logic              cmd_done
);
    localparam logic [ADDR_W-1:0]  HALF_W = ADDR_W'(FB_WIDTH / 2);
    localparam logic [FIELD_W-1:0] FB_W   = FIELD_W'(FB_WIDTH);
    localparam logic [FIELD_W-1:0] FB_H   = FIELD_W'(FB_HEIGHT);

    fill_state_t        state_q;
    logic               rdy_q;
    logic               rts_q;
    logic               busy_q;
    logic               done_q;
    logic               op_q;
    logic [WORD_W-1:0]  data_q;
    logic [ADDR_W-1:0]  row_addr_q;
    logic [FIELD_W-1:0] nwords_q;
    logic [FIELD_W-1:0] rows_q;
    logic               first_hi_q;
    logic               last_lo_q;

    logic [CMD_W-1:0]   fifo_dout;
    logic               fifo_full_c;
    logic               fifo_empty_c;
    logic               push_c;
    logic               pop_c;
    logic               unused_bits;

    // Command FIFO; a full FIFO still accepts when the head is popped the same cycle.
    assign pop_c      = (state_q == ST_SETUP);
    assign cmd_in_rtr = rdy_q & (~fifo_full_c | pop_c);
    assign push_c     = cmd_in_rts & cmd_in_rtr;

    fifo #(
        .DATA_WIDTH (CMD_W),
        .DEPTH      (CMD_DEPTH),
        .LOG2       (CMD_LOG2)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_    (rst_),
        .push    (push_c),
        .din     (cmd_in_data),
        .pop     (pop_c),
        .dout    (fifo_dout),
        .full_c  (fifo_full_c),
        .empty_c (fifo_empty_c)
    );

    // Decode of the FIFO head.
    fill_cmd_t cmd_c;
    assign cmd_c.x = swap16(fifo_dout[15:0]);
    assign cmd_c.y = swap16(fifo_dout[31:16]);
    assign cmd_c.w = swap16(fifo_dout[47:32]);
    assign cmd_c.h = swap16(fifo_dout[63:48]);
    assign cmd_c.r = fifo_dout[67:64];
    assign cmd_c.g = fifo_dout[75:72];
    assign cmd_c.b = fifo_dout[83:80];
    assign unused_bits = ^{fifo_dout[87:84], fifo_dout[79:76], fifo_dout[71:68]};

    logic [FIELD_W-1:0] w_eff_c;
    logic [FIELD_W-1:0] h_eff_c;
    logic               clip_out_c;

`ifdef RECT_CLIP_EN
    always_comb begin
        clip_out_c = (cmd_c.x >= FB_W) || (cmd_c.y >= FB_H);
        w_eff_c    = cmd_c.w;
        h_eff_c    = cmd_c.h;
        if (!clip_out_c) begin
            if (cmd_c.w > FB_W - cmd_c.x) w_eff_c = FB_W - cmd_c.x;
            if (cmd_c.h > FB_H - cmd_c.y) h_eff_c = FB_H - cmd_c.y;
        end
    end
`else
    logic unused_fb;
    assign unused_fb  = ^{FB_W, FB_H};
    assign clip_out_c = 1'b0;
    assign w_eff_c    = cmd_c.w;
    assign h_eff_c    = cmd_c.h;
`endif

    logic                empty_rect_c;
    logic [FIELD_W-1:0]  span_end_c;
    logic [FIELD_W-1:0]  nwords_c;
    logic [ADDR_W-1:0]   row_addr_c;
    logic [PIX_W-1:0]    pix_c;

    assign empty_rect_c = clip_out_c || (w_eff_c == '0) || (h_eff_c == '0);
    assign span_end_c   = cmd_c.x + w_eff_c - FIELD_W'(1);
    assign nwords_c     = (span_end_c >> 1) - (cmd_c.x >> 1) + FIELD_W'(1);
    assign row_addr_c   = ADDR_W'(cmd_c.y) * HALF_W + ADDR_W'(cmd_c.x >> 1);
    assign pix_c        = {4'h0, cmd_c.r, cmd_c.g, cmd_c.b};

    // Row walker is reloaded at setup and on every row advance.
    logic               wg_load_c;
    logic               wg_adv_c;
    logic               wg_last_c;
    logic [ADDR_W-1:0]  wg_base_c;
    logic [ADDR_W-1:0]  wg_addr;
    logic [WBEN_W-1:0]  wg_wben;
    logic               xfer_c;

    assign xfer_c    = rts_q & arb_in_rtr;
    assign wg_load_c = (pop_c && !empty_rect_c) || (state_q == ST_NEXT && rows_q != FIELD_W'(1));
    assign wg_adv_c  = (state_q == ST_ROW) && xfer_c && !wg_last_c;
    assign wg_base_c = pop_c ? row_addr_c : row_addr_q + HALF_W;

    rect_word_gen #(
        .ADDR_W (ADDR_W)
    ) u_word_gen (
        .clk       (clk),
        .rst_      (rst_),
        .load      (wg_load_c),
        .base_addr (wg_base_c),
        .nwords    (pop_c ? nwords_c : nwords_q),
        .first_hi  (pop_c ? cmd_c.x[0] : first_hi_q),
        .last_lo   (pop_c ? ~span_end_c[0] : last_lo_q),
        .advance   (wg_adv_c),
        .addr      (wg_addr),
        .wben      (wg_wben),
        .last_c    (wg_last_c)
    );

    // Command sequencer.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q    <= ST_IDLE;
            rdy_q      <= 1'b0;
            rts_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            op_q       <= 1'b0;
            data_q     <= '0;
            row_addr_q <= '0;
            nwords_q   <= '0;
            rows_q     <= '0;
            first_hi_q <= 1'b0;
            last_lo_q  <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_c) begin
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    data_q     <= {pix_c, pix_c};
                    op_q       <= OP_WRITE;
                    row_addr_q <= row_addr_c;
                    nwords_q   <= nwords_c;
                    rows_q     <= h_eff_c;
                    first_hi_q <= cmd_c.x[0];
                    last_lo_q  <= ~span_end_c[0];
                    if (empty_rect_c) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_ROW;
                        rts_q   <= 1'b1;
                    end
                end
                ST_ROW: begin
                    if (xfer_c && wg_last_c) begin
                        rts_q   <= 1'b0;
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    rows_q <= rows_q - FIELD_W'(1);
                    if (rows_q == FIELD_W'(1)) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        row_addr_q <= row_addr_q + HALF_W;
                        rts_q      <= 1'b1;
                        state_q    <= ST_ROW;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign arb_out_data = data_q;
    assign arb_out_addr = wg_addr;
    assign arb_out_wben = wg_wben;
    assign arb_out_op   = op_q;
    assign arb_out_rts  = rts_q;
    assign busy         = busy_q;
    assign cmd_done     = done_q;
endmodule

// File: tb/tb_rect_fill_engine_v2.sv
// Scoreboard bench for rect_fill_engine_v2: directed commands queue expected writes, a negedge monitor checks them.
module tb_rect_fill_engine_v2;
    logic        clk = 1'b0;
    logic        rst_;
    logic [87:0] cmd_in_data;
    logic        cmd_in_rts;
    logic        cmd_in_rtr;
    logic [31:0] arb_out_data;
    logic [15:0] arb_out_addr;
    logic [3:0]  arb_out_wben;
    logic        arb_out_op;
    logic        arb_out_rts;
    logic        arb_in_rtr;
    logic        busy;
    logic        cmd_done;

    rect_fill_engine_v2 dut (
        .clk          (clk),
        .rst_         (rst_),
        .cmd_in_data  (cmd_in_data),
        .cmd_in_rts   (cmd_in_rts),
        .cmd_in_rtr   (cmd_in_rtr),
        .arb_out_data (arb_out_data),
        .arb_out_addr (arb_out_addr),
        .arb_out_wben (arb_out_wben),
        .arb_out_op   (arb_out_op),
        .arb_out_rts  (arb_out_rts),
        .arb_in_rtr   (arb_in_rtr),
        .busy         (busy),
        .cmd_done     (cmd_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_done;
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  wben;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   rtr_mode = 0;   // 0: always ready, 1: random, 2: never ready

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic exp_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] be);
        exp_t e;
        e.is_done = 1'b0; e.addr = a; e.data = d; e.wben = be;
        exp_q.push_back(e);
    endtask

    task automatic exp_done();
        exp_t e;
        e = '0;
        e.is_done = 1'b1;
        exp_q.push_back(e);
    endtask

    function automatic logic [87:0] mk_cmd(input logic [15:0] x, input logic [15:0] y,
                                           input logic [15:0] w, input logic [15:0] h,
                                           input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        logic [87:0] d;
        d = '0;
        d[87:84] = 4'h9; d[79:76] = 4'h3; d[71:68] = 4'h6;
        d[7:0]   = x[15:8]; d[15:8]  = x[7:0];
        d[23:16] = y[15:8]; d[31:24] = y[7:0];
        d[39:32] = w[15:8]; d[47:40] = w[7:0];
        d[55:48] = h[15:8]; d[63:56] = h[7:0];
        d[67:64] = r; d[75:72] = g; d[83:80] = b;
        return d;
    endfunction

    // Arbiter ready driver, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rtr_mode)
            0:       arb_in_rtr = 1'b1;
            1:       arb_in_rtr = 1'($urandom_range(0, 1));
            default: arb_in_rtr = 1'b0;
        endcase
    end

    // Monitor / scoreboard.
    logic        stall_prev = 1'b0;
    logic        done_prev  = 1'b0;
    logic [53:0] hold_prev;
    exp_t        got;
    always @(negedge clk) begin
        if (!rst_) begin
            stall_prev = 1'b0;
            done_prev  = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_hold", 64'({arb_out_rts, arb_out_addr, arb_out_data, arb_out_wben, arb_out_op}),
                      64'(hold_prev));
            if (done_prev) check("busy_after_done", 64'(busy), 64'(0));
            done_prev = cmd_done;
            if (arb_out_rts && arb_in_rtr) begin
                check("write_expected", 64'(exp_q.size() != 0 && !exp_q[0].is_done), 64'(1));
                if (exp_q.size() != 0 && !exp_q[0].is_done) begin
                    got = exp_q.pop_front();
                    check("write", 64'({arb_out_op, arb_out_addr, arb_out_data, arb_out_wben}),
                          64'({1'b1, got.addr, got.data, got.wben}));
                end
            end
            if (cmd_done) begin
                check("busy_in_done", 64'({busy, arb_out_rts}), 64'(2'b10));
                check("done_expected", 64'(exp_q.size() != 0 && exp_q[0].is_done), 64'(1));
                if (exp_q.size() != 0 && exp_q[0].is_done) void'(exp_q.pop_front());
            end
            stall_prev = arb_out_rts && !arb_in_rtr;
            hold_prev  = {1'b1, arb_out_addr, arb_out_data, arb_out_wben, arb_out_op};
        end
    end

    task automatic push_cmd(input logic [87:0] d);
        bit ok = 1'b0;
        @(posedge clk); #2;
        cmd_in_data = d;
        cmd_in_rts  = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            ok = cmd_in_rtr;
            @(posedge clk); #2;
        end
        cmd_in_rts = 1'b0;
        if (!ok) check("push_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && !busy;
        end
        if (!ok) check({name, "_timeout"}, 64'(exp_q.size()), 64'(0));
    endtask

    int lat;
    int accepted;
    int seen;

    initial begin
        rst_ = 1'b0; cmd_in_rts = 1'b0; cmd_in_data = '0; arb_in_rtr = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs", 64'({cmd_in_rtr, arb_out_rts, busy, cmd_done, arb_out_op, arb_out_wben}), 64'(0));
        check("reset_data", 64'({arb_out_data, arb_out_addr}), 64'(0));
        rst_ = 1'b1;
        @(negedge clk);
        check("rtr_after_reset", 64'(cmd_in_rtr), 64'(1));

        // 1: two full rows, plus first-write latency
        exp_wr(16'd0, 32'h0F000F00, 4'hF); exp_wr(16'd1, 32'h0F000F00, 4'hF);
        exp_wr(16'd160, 32'h0F000F00, 4'hF); exp_wr(16'd161, 32'h0F000F00, 4'hF); exp_done();
        push_cmd(mk_cmd(16'd0, 16'd0, 16'd4, 16'd1 + 16'd1, 4'hF, 4'h0, 4'h0));
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arb_out_rts) break;
            lat++;
        end
        check("first_rts_latency", 64'(lat), 64'(2));
        wait_idle("t1");

        // 2: odd start, even end
        exp_wr(16'd161, 32'h01230123, 4'b1100); exp_wr(16'd162, 32'h01230123, 4'b1111);
        exp_wr(16'd163, 32'h01230123, 4'b0011); exp_done();
        push_cmd(mk_cmd(16'd3, 16'd1, 16'd4, 16'd1, 4'h1, 4'h2, 4'h3));
        wait_idle("t2");

        // 3: zero width
        exp_done();
        push_cmd(mk_cmd(16'd5, 16'd5, 16'd0, 16'd5, 4'h4, 4'h4, 4'h4));
        wait_idle("t3");

        // single-pixel rows at both parities
        exp_wr(16'd322, 32'h07770777, 4'b1100); exp_wr(16'd482, 32'h07770777, 4'b1100); exp_done();
        push_cmd(mk_cmd(16'd5, 16'd2, 16'd1, 16'd2, 4'h7, 4'h7, 4'h7));
        exp_wr(16'd2, 32'h0ABC0ABC, 4'b0011); exp_done();
        push_cmd(mk_cmd(16'd4, 16'd0, 16'd1, 16'd1, 4'hA, 4'hB, 4'hC));
        wait_idle("single");

        // 4: test 1 with a randomly stalling arbiter
        rtr_mode = 1;
        exp_wr(16'd0, 32'h0F000F00, 4'hF); exp_wr(16'd1, 32'h0F000F00, 4'hF);
        exp_wr(16'd160, 32'h0F000F00, 4'hF); exp_wr(16'd161, 32'h0F000F00, 4'hF); exp_done();
        push_cmd(mk_cmd(16'd0, 16'd0, 16'd4, 16'd2, 4'hF, 4'h0, 4'h0));
        wait_idle("t4");
        rtr_mode = 0;

        // 5: span past the right edge
`ifdef RECT_CLIP_EN
        exp_wr(16'd159, 32'h00A500A5, 4'hF);
`else
        for (int a = 159; a <= 163; a++) exp_wr(16'(a), 32'h00A500A5, 4'hF);
`endif
        exp_done();
        push_cmd(mk_cmd(16'd318, 16'd0, 16'd10, 16'd1, 4'h0, 4'hA, 4'h5));
        wait_idle("t5");

        // 6: fill the FIFO against a stalled arbiter, then reset mid-row
        rtr_mode = 2;
        @(posedge clk); #2;
        accepted = 0;
        cmd_in_data = mk_cmd(16'd0, 16'd0, 16'd2, 16'd1, 4'h1, 4'h1, 4'h1);
        for (int i = 0; i < 40; i++) begin
            cmd_in_rts = 1'b1;
            if (cmd_in_rtr) accepted++;
            @(posedge clk); #2;
        end
        cmd_in_rts = 1'b0;
        check("fifo_accept_count", 64'(accepted), 64'(33));
        check("fifo_full_rtr", 64'({cmd_in_rtr, arb_out_rts, busy}), 64'(3'b011));
        #1 rst_ = 1'b0;
        #1;
        check("async_reset_outs", 64'({arb_out_rts, cmd_in_rtr, busy, cmd_done}), 64'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_ = 1'b1;
        rtr_mode = 0;
        @(negedge clk);
        check("rtr_after_reset2", 64'(cmd_in_rtr), 64'(1));
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy || arb_out_rts || cmd_done) seen++;
        end
        check("fifo_flushed", 64'(seen), 64'(0));

        exp_wr(16'd161, 32'h01230123, 4'b1100); exp_wr(16'd162, 32'h01230123, 4'b1111);
        exp_wr(16'd163, 32'h01230123, 4'b0011); exp_done();
        push_cmd(mk_cmd(16'd3, 16'd1, 16'd4, 16'd1, 4'h1, 4'h2, 4'h3));
        wait_idle("post_reset");

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
